div_unit: RTL

- Multi-cycle 32-bit integer divider for DIV/DIVU; the responder side of the start/ready handshake driven by the EX stage.
- EX asserts start_i with the operands and stalls until ready_o. The result then travels down the HI/LO write path: remainder to HI, quotient to LO.
- Restoring shift-subtract, one quotient bit per cycle, with an annul input so a flushed instruction can abandon the division.

---
 rtl/div_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit -- multi-cycle restoring divider for DIV/DIVU.
//
// Produces one quotient bit per cycle, MSB first, working on magnitudes and
// fixing the signs at the end. This is the responder side of the EX stage's
// start/ready handshake. The result is held while start_i stays high.
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   signed_div_i  1 = DIV (signed), 0 = DIVU
//   opdata1_i     dividend, sampled only on the accepting edge
//   opdata2_i     divisor, sampled only on the accepting edge
//   start_i       request, held by EX until ready_o
//   annul_i       flush: abandon the division in flight
//   result_o      {remainder, quotient}, zero unless ready_o
//   ready_o       result valid
module div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

    // Request attributes captured at accept time, needed for sign correction.
    typedef struct packed {
        logic sgn;
        logic neg_a;
        logic neg_b;
    } req_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    req_t                req_q;
    logic [DATA_W-1:0]   dvd_q;   // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0]   dvs_q;
    logic [DATA_W-1:0]   rem_q;
    logic [2*DATA_W-1:0] res_q;

    logic                accept;
    logic                last_step;
    logic [DATA_W-1:0]   abs_a, abs_b;
    logic [DATA_W:0]     shifted;
    logic [DATA_W+1:0]   diff;
    logic [DATA_W-1:0]   rem_nx, dvd_nx;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    assign accept    = start_i && !annul_i;
    assign last_step = (cnt_q == CNT_W'(DATA_W));

    // A negative dividend or divisor is only stored as a magnitude for DIV.
    assign abs_a = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign abs_b = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    // One restoring step. The shifted remainder needs DATA_W+1 bits. The
    // subtraction is widened by one more bit so the borrow shows up cleanly.
    always_comb begin
        shifted = {rem_q, dvd_q[DATA_W-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_q};
        rem_nx  = shifted[DATA_W-1:0];
        dvd_nx  = {dvd_q[DATA_W-2:0], 1'b0};
        if (!diff[DATA_W+1]) begin
            rem_nx = diff[DATA_W-1:0];
            dvd_nx = {dvd_q[DATA_W-2:0], 1'b1};
        end
    end

    // Quotient is negative iff the signs differ. The remainder takes the
    // dividend's sign. -2^31 / -1 wraps back to 0x80000000.
    assign quo_fix = (req_q.sgn && (req_q.neg_a ^ req_q.neg_b)) ? -dvd_q : dvd_q;
    assign rem_fix = (req_q.sgn && req_q.neg_a) ? -rem_q : rem_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FREE;
        else     state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FREE:   if (accept) state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
            S_BYZERO: state_d = annul_i ? S_FREE : S_END;
            S_ON: begin
                if (annul_i)        state_d = S_FREE;
                else if (last_step) state_d = S_END;
            end
            S_END:    if (!start_i || annul_i) state_d = S_FREE;
            default:  state_d = S_FREE;
        endcase
    end

    // Outputs: valid only in END, zero everywhere else.
    always_comb begin
        ready_o  = (state_q == S_END);
        result_o = ready_o ? res_q : '0;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            req_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            res_q <= '0;
        end else begin
            case (state_q)
                S_FREE: begin
                    if (accept && opdata2_i != '0) begin
                        req_q <= '{sgn:   signed_div_i,
                                   neg_a: opdata1_i[DATA_W-1],
                                   neg_b: opdata2_i[DATA_W-1]};
                        dvd_q <= abs_a;
                        dvs_q <= abs_b;
                        rem_q <= '0;
                        cnt_q <= '0;
                    end
                end
                S_BYZERO: res_q <= '0;
                S_ON: begin
                    if (annul_i) begin
                        cnt_q <= '0;
                    end else if (!last_step) begin
                        rem_q <= rem_nx;
                        dvd_q <= dvd_nx;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        res_q <= {rem_fix, quo_fix};
                        cnt_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
